generic_spi_controller_engine: RTL and testbench

- Bit-level SPI shift engine in the spi_clk domain, directly downstream of generic_spi_controller_interface.
- Reads transmit words from the interface's TX memory, drives pico/cs_b, samples poci and writes received words back to the RX memory.
- A transaction is started by a one-cycle start pulse carrying a bit length. Completion is reported with busy/done back to the interface's CDC logic.
- spi_clk is forwarded to the target unchanged; this block generates no SCLK.

---
 rtl/generic_spi_controller_engine.sv | 130 +++++++++++++
 tb/tb_generic_spi_controller_engine.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/generic_spi_controller_engine.sv
// Bit-level SPI shift engine: streams TX memory words out on pico MSB-first,
// samples poci into RX memory words, and frames the transfer with cs_b.
module generic_spi_controller_engine #(
  parameter int MEM_DEPTH  = 64,
  parameter int WORD_WIDTH = 32,
  parameter int LEN_WIDTH  = 12
) (
  input  logic                         spi_clk,
  input  logic                         spi_rst,
  input  logic                         start,
  input  logic [LEN_WIDTH-1:0]         trans_len,
  output logic                         busy,
  output logic                         done,
  output logic [$clog2(MEM_DEPTH)-1:0] tx_rd_addr,
  input  logic [WORD_WIDTH-1:0]        tx_rd_data,
  output logic                         rx_wr_en,
  output logic [$clog2(MEM_DEPTH)-1:0] rx_wr_addr,
  output logic [WORD_WIDTH-1:0]        rx_wr_data,
  input  logic                         poci,
  output logic                         pico,
  output logic                         cs_b,
  output logic [2:0]                   fsm_state
);

  localparam int TOTAL_BITS = MEM_DEPTH * WORD_WIDTH;
  localparam int AW = $clog2(MEM_DEPTH);
  localparam int BW = $clog2(WORD_WIDTH);

  typedef enum logic [2:0] {IDLE, FETCH, LOAD, SHIFT, FINISH} state_t;

  state_t                state;
  logic [LEN_WIDTH-1:0]  n_bits;
  logic [LEN_WIDTH-1:0]  bit_cnt;
  logic [BW-1:0]         bit_idx;
  logic [AW-1:0]         word_idx;
  logic [WORD_WIDTH-1:0] tx_sr;
  logic [WORD_WIDTH-1:0] rx_sr;
  logic [WORD_WIDTH-1:0] rx_shift;
  logic                  last_bit;
  logic                  word_end;

  assign fsm_state = state;
  assign rx_shift  = {rx_sr[WORD_WIDTH-2:0], poci};
  assign last_bit  = (bit_cnt + 1'b1) == n_bits;
  assign word_end  = bit_idx == BW'(WORD_WIDTH - 1);

  always_ff @(posedge spi_clk) begin
    if (spi_rst) begin
      state      <= IDLE;
      cs_b       <= 1'b1;
      pico       <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      rx_wr_en   <= 1'b0;
      tx_rd_addr <= '0;
      rx_wr_addr <= '0;
      rx_wr_data <= '0;
      n_bits     <= '0;
      bit_cnt    <= '0;
      bit_idx    <= '0;
      word_idx   <= '0;
      tx_sr      <= '0;
      rx_sr      <= '0;
    end else begin
      done     <= 1'b0;
      rx_wr_en <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (trans_len == '0) begin
              done <= 1'b1;
            end else begin
              n_bits     <= (int'(trans_len) > TOTAL_BITS) ? LEN_WIDTH'(TOTAL_BITS) : trans_len;
              busy       <= 1'b1;
              tx_rd_addr <= '0;
              state      <= FETCH;
            end
          end
        end
        FETCH: state <= LOAD;
        LOAD: begin
          tx_sr    <= tx_rd_data;
          pico     <= tx_rd_data[WORD_WIDTH-1];
          cs_b     <= 1'b0;
          bit_cnt  <= '0;
          bit_idx  <= '0;
          word_idx <= '0;
          rx_sr    <= '0;
          state    <= SHIFT;
        end
        SHIFT: begin
          bit_cnt <= bit_cnt + 1'b1;
          bit_idx <= word_end ? '0 : bit_idx + 1'b1;
          if (last_bit) begin
            // The final word, full or partial, is written from FINISH.
            rx_sr <= rx_shift;
            cs_b  <= 1'b1;
            pico  <= 1'b0;
            state <= FINISH;
          end else if (word_end) begin
            rx_wr_en   <= 1'b1;
            rx_wr_addr <= word_idx;
            rx_wr_data <= rx_shift;
            rx_sr      <= '0;
            word_idx   <= word_idx + 1'b1;
            tx_sr      <= tx_rd_data;
            pico       <= tx_rd_data[WORD_WIDTH-1];
          end else begin
            rx_sr <= rx_shift;
            tx_sr <= tx_sr << 1;
            pico  <= tx_sr[WORD_WIDTH-2];
          end
          // Prefetch two cycles ahead so the next word loads with no gap.
          if (bit_idx == BW'(WORD_WIDTH - 3) && word_idx != AW'(MEM_DEPTH - 1))
            tx_rd_addr <= word_idx + 1'b1;
        end
        FINISH: begin
          rx_wr_en   <= 1'b1;
          rx_wr_addr <= word_idx;
          rx_wr_data <= rx_sr;
          done       <= 1'b1;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_generic_spi_controller_engine.sv
// Bench for generic_spi_controller_engine: directed and random transfers
// checked against a bit-stream model of the TX/RX memories.
module tb_generic_spi_controller_engine;

  localparam int W    = 32;
  localparam int D    = 64;
  localparam int LW   = 12;
  localparam int MAXB = D * W;

  logic          spi_clk = 1'b0;
  logic          spi_rst = 1'b1;
  logic          start   = 1'b0;
  logic [LW-1:0] trans_len = '0;
  logic          busy, done, rx_wr_en, pico, cs_b, poci;
  logic [5:0]    tx_rd_addr, rx_wr_addr;
  logic [W-1:0]  tx_rd_data, rx_wr_data;
  logic [2:0]    fsm_state;

  logic [W-1:0]  tx_mem [D];
  logic          poci_bits [MAXB];
  logic          loop_en = 1'b0;
  logic          poci_r  = 1'b0;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  generic_spi_controller_engine #(.MEM_DEPTH(D), .WORD_WIDTH(W), .LEN_WIDTH(LW)) dut (
    .spi_clk(spi_clk), .spi_rst(spi_rst), .start(start), .trans_len(trans_len),
    .busy(busy), .done(done), .tx_rd_addr(tx_rd_addr), .tx_rd_data(tx_rd_data),
    .rx_wr_en(rx_wr_en), .rx_wr_addr(rx_wr_addr), .rx_wr_data(rx_wr_data),
    .poci(poci), .pico(pico), .cs_b(cs_b), .fsm_state(fsm_state)
  );

  // clock / memory model
  always #5 spi_clk = ~spi_clk;
  always @(posedge spi_clk) cyc <= cyc + 1;
  always @(posedge spi_clk) tx_rd_data <= tx_mem[tx_rd_addr];
  assign poci = loop_en ? pico : poci_r;

  // monitor
  int   low_cnt, done_cnt, fall_edge, rise_edge, done_edge;
  logic prev_cs = 1'b1;
  logic         pico_q [$];
  logic [5:0]   wa_q [$];
  logic [W-1:0] wd_q [$];

  always @(negedge spi_clk) begin
    if (!cs_b && prev_cs) fall_edge = cyc;
    if (cs_b && !prev_cs) rise_edge = cyc;
    prev_cs = cs_b;
    if (!cs_b) begin
      pico_q.push_back(pico);
      poci_r = (low_cnt < MAXB) ? poci_bits[low_cnt] : 1'b0;
      low_cnt++;
    end
    if (rx_wr_en) begin
      wa_q.push_back(rx_wr_addr);
      wd_q.push_back(rx_wr_data);
    end
    if (done) begin
      done_cnt++;
      done_edge = cyc;
    end
  end

  // reference model
  function automatic logic tx_bit(input int j);
    logic [W-1:0] w;
    w = tx_mem[j / W];
    return w[W-1-(j % W)];
  endfunction

  function automatic logic src_bit(input int j);
    return loop_en ? tx_bit(j) : poci_bits[j];
  endfunction

  function automatic logic [W-1:0] exp_word(input int k, input int n);
    logic [W-1:0] v;
    int b;
    v = '0;
    b = ((n - k * W) < W) ? (n - k * W) : W;
    for (int t = 0; t < b; t++) v = {v[W-2:0], src_bit(k * W + t)};
    return v;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    low_cnt = 0; done_cnt = 0;
    fall_edge = -1; rise_edge = -1; done_edge = -1;
    pico_q.delete(); wa_q.delete(); wd_q.delete();
  endtask

  // driver tasks: entered and left at negedge+1
  task automatic start_txn(input int len, input logic exp_busy, output int e0);
    clear_mon();
    start = 1'b1;
    trans_len = LW'(len);
    @(posedge spi_clk); #1;
    e0 = cyc;
    start = 1'b0;
    @(negedge spi_clk); #1;
    chk("busy_after_start", busy, exp_busy);
  endtask

  task automatic wait_done(input int limit);
    int i;
    i = 0;
    while (done_cnt == 0 && i < limit) begin
      @(negedge spi_clk); #1;
      i++;
    end
    chk("done_seen", done_cnt > 0, 1'b1);
  endtask

  task automatic check_txn(input int len, input int e0);
    int n, nw, pbad, abad, dbad;
    n  = (len > MAXB) ? MAXB : len;
    nw = (n + W - 1) / W;
    pbad = 0; abad = 0; dbad = 0;
    chk("done_count", done_cnt, 1);
    chk("busy_end", busy, 1'b0);
    if (n == 0) begin
      chk("zero_done_edge", done_edge, e0);
      chk("zero_cs_fall", fall_edge, -1);
      chk("zero_low_cnt", low_cnt, 0);
      chk("zero_wr_cnt", wa_q.size(), 0);
    end else begin
      chk("cs_fall_edge", fall_edge, e0 + 2);
      chk("cs_rise_edge", rise_edge, e0 + 2 + n);
      chk("cs_low_cycles", low_cnt, n);
      chk("done_edge", done_edge, e0 + 3 + n);
      chk("pico_len", pico_q.size(), n);
      for (int j = 0; j < n && j < pico_q.size(); j++)
        if (pico_q[j] !== tx_bit(j)) pbad++;
      chk("pico_bits", pbad, 0);
      chk("rx_wr_cnt", wa_q.size(), nw);
      for (int k = 0; k < nw && k < wa_q.size(); k++) begin
        if (wa_q[k] !== 6'(k)) abad++;
        if (wd_q[k] !== exp_word(k, n)) dbad++;
      end
      chk("rx_wr_addr", abad, 0);
      chk("rx_wr_data", dbad, 0);
    end
  endtask

  task automatic run(input int len);
    int e0;
    start_txn(len, len > 0, e0);
    wait_done(6000);
    check_txn(len, e0);
    @(negedge spi_clk); #1;
    chk("done_one_cycle", done, 1'b0);
  endtask

  initial begin
    int e0, e1, i;
    for (int d = 0; d < D; d++) tx_mem[d] = $urandom;
    for (int b = 0; b < MAXB; b++) poci_bits[b] = 1'($urandom_range(0, 1));
    clear_mon();

    // reset and idle
    repeat (3) @(negedge spi_clk);
    #1 spi_rst = 1'b0;
    clear_mon();
    repeat (10) @(negedge spi_clk);
    #1;
    chk("idle_cs_b", cs_b, 1'b1);
    chk("idle_pico", pico, 1'b0);
    chk("idle_busy", busy, 1'b0);
    chk("idle_done", done_cnt, 0);
    chk("idle_wr", wa_q.size(), 0);
    chk("idle_tx_addr", tx_rd_addr, 6'd0);
    chk("idle_rx_addr", rx_wr_addr, 6'd0);
    chk("idle_rx_data", rx_wr_data, 32'd0);

    // single word loopback
    loop_en = 1'b1;
    tx_mem[0] = 32'hA5A5_0F0F;
    run(32);
    if (wd_q.size() > 0) chk("word0_data", wd_q[0], 32'hA5A5_0F0F);

    // word boundary plus partial word
    tx_mem[0] = 32'h1234_5678;
    tx_mem[1] = 32'h9ABC_DEF0;
    run(40);
    if (wd_q.size() > 1) begin
      chk("w40_rx0", wd_q[0], 32'h1234_5678);
      chk("w40_rx1", wd_q[1], 32'h0000_009A);
    end

    // zero length
    run(0);

    // random poci, assorted lengths
    loop_en = 1'b0;
    for (int d = 0; d < D; d++) tx_mem[d] = $urandom;
    run(1);
    run(31);
    run(33);
    run(64);
    for (int r = 0; r < 3; r++) run($urandom_range(2, 300));

    // clamp
    run(4000);

    // reset mid-transfer
    start_txn(64, 1'b1, e0);
    i = 0;
    while (low_cnt < 10 && i < 100) begin
      @(negedge spi_clk); #1;
      i++;
    end
    chk("abort_reached", low_cnt >= 10, 1'b1);
    spi_rst = 1'b1;
    @(posedge spi_clk); #1;
    chk("abort_cs_b", cs_b, 1'b1);
    chk("abort_busy", busy, 1'b0);
    @(negedge spi_clk); #1;
    spi_rst = 1'b0;
    repeat (100) @(negedge spi_clk);
    #1;
    chk("abort_no_done", done_cnt, 0);
    chk("abort_no_wr", wa_q.size(), 0);
    run(50);

    // start while busy ignored, then start in the done cycle
    start_txn(40, 1'b1, e0);
    repeat (8) @(negedge spi_clk);
    #1;
    start = 1'b1;
    trans_len = LW'(5);
    @(negedge spi_clk); #1;
    start = 1'b0;
    wait_done(6000);
    check_txn(40, e0);
    start_txn(8, 1'b1, e1);
    wait_done(6000);
    check_txn(8, e1);
    @(negedge spi_clk); #1;
    chk("b2b_done_one_cycle", done, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
